// File: rtl/voting_pkg.sv
// Shared types and sizing helpers for the sequential voting tally.
// Used by voting_tally_seq and voting_counter_bank.
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int nc_of(input int cand_bits);
    return 1 << cand_bits;
  endfunction

  function automatic int cnt_w_of(input int max_votes);
    return $clog2(max_votes + 1);
  endfunction

  // Holder for the width-dependent counter array type.
  virtual class cnt_types #(parameter int CAND_BITS = 2, parameter int CNT_W = 3);
    typedef logic [(1 << CAND_BITS)-1:0][CNT_W-1:0] cnt_arr_t;
  endclass

endpackage

// File: rtl/voting_counter_bank.sv
// Bank of NC saturating vote counters: synchronous clear, one-hot increment,
// and a registered read port count[rd_idx] consumed by the argmax scan.
module voting_counter_bank
  import voting_pkg::*;
#(
  parameter int CAND_BITS = 2,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc_en,
  input  logic [CAND_BITS-1:0] inc_idx,
  input  logic [CAND_BITS-1:0] rd_idx,
  output logic [CNT_W-1:0]     rd_count
);

  localparam int NC = nc_of(CAND_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef cnt_types#(CAND_BITS, CNT_W)::cnt_arr_t cnt_arr_t;

  cnt_arr_t          count_reg;
  logic [NC-1:0]     hit;
  logic [CNT_W-1:0]  rd_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_hit
      assign hit[gi] = inc_en && (inc_idx == CAND_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (clr)
          count_reg[i] <= '0;
        else if (hit[i] && count_reg[i] != CNT_MAX)
          count_reg[i] <= count_reg[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_count_reg <= '0;
    else     rd_count_reg <= count_reg[rd_idx];
  end

  assign rd_count = rd_count_reg;

endmodule

// File: rtl/voting_tally_seq.sv
// Sequential ballot tally with a one-candidate-per-cycle argmax scan and a held
// result handshake. Optional tie output is enabled by defining VOTING_TALLY_TIE_EN.
module voting_tally_seq
  import voting_pkg::*;
#(
  parameter int CAND_BITS = 2,
  parameter int MAX_VOTES = 4,
  parameter int CNT_W     = cnt_w_of(MAX_VOTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ballot_valid,
  input  logic [CAND_BITS-1:0] ballot,
  output logic                 ballot_ready,
  input  logic                 close,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CAND_BITS-1:0] winner,
  output logic [CNT_W-1:0]     winner_count
`ifdef VOTING_TALLY_TIE_EN
  ,
  output logic                 tie
`endif
);

  localparam int IW = CAND_BITS + 1;
  localparam int NC = nc_of(CAND_BITS);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_VOTES);
  localparam logic [IW-1:0]    LAST  = IW'(NC);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     total_reg, total_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic [CAND_BITS-1:0] best_idx_reg, best_idx_next;
  logic [CNT_W-1:0]     best_cnt_reg, best_cnt_next;
  logic [CAND_BITS-1:0] winner_reg, winner_next;
  logic [CNT_W-1:0]     winner_count_reg, winner_count_next;
  logic                 result_valid_reg, result_valid_next;
`ifdef VOTING_TALLY_TIE_EN
  logic                 eq_reg, eq_next;
  logic                 tie_reg, tie_next;
`endif

  logic                 clr;
  logic                 accept;
  logic [CNT_W-1:0]     rd_count;
  logic [CAND_BITS-1:0] cand;

  assign ballot_ready = (state_reg == COLLECT) && (total_reg < MAX_V);
  assign accept       = ballot_valid && ballot_ready;
  assign clr          = (state_reg == IDLE) && start;
  // The read port is registered, so the count arriving now belongs to idx_reg-1.
  assign cand         = CAND_BITS'(idx_reg - IW'(1));

  voting_counter_bank #(
    .CAND_BITS (CAND_BITS),
    .CNT_W     (CNT_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc_en   (accept),
    .inc_idx  (ballot),
    .rd_idx   (idx_reg[CAND_BITS-1:0]),
    .rd_count (rd_count)
  );

  always_comb begin
    state_next        = state_reg;
    total_next        = total_reg;
    idx_next          = idx_reg;
    best_idx_next     = best_idx_reg;
    best_cnt_next     = best_cnt_reg;
    winner_next       = winner_reg;
    winner_count_next = winner_count_reg;
    result_valid_next = result_valid_reg;
`ifdef VOTING_TALLY_TIE_EN
    eq_next           = eq_reg;
    tie_next          = tie_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
          total_next = '0;
        end
      end
      COLLECT: begin
        if (accept)
          total_next = total_reg + CNT_W'(1);
        if (close) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        idx_next = idx_reg + IW'(1);
        if (idx_reg != '0) begin
          // First candidate seeds the best; later ones win only if strictly greater.
          if (idx_reg == IW'(1) || rd_count > best_cnt_reg) begin
            best_idx_next = cand;
            best_cnt_next = rd_count;
`ifdef VOTING_TALLY_TIE_EN
            eq_next       = 1'b0;
          end else if (rd_count == best_cnt_reg) begin
            eq_next       = 1'b1;
`endif
          end
        end
        if (idx_reg == LAST) begin
          state_next        = DONE;
          winner_next       = best_idx_next;
          winner_count_next = best_cnt_next;
          result_valid_next = 1'b1;
`ifdef VOTING_TALLY_TIE_EN
          tie_next          = eq_next;
`endif
        end
      end
      DONE: begin
        if (result_ready) begin
          state_next        = IDLE;
          result_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      total_reg        <= '0;
      idx_reg          <= '0;
      best_idx_reg     <= '0;
      best_cnt_reg     <= '0;
      winner_reg       <= '0;
      winner_count_reg <= '0;
      result_valid_reg <= 1'b0;
`ifdef VOTING_TALLY_TIE_EN
      eq_reg           <= 1'b0;
      tie_reg          <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      total_reg        <= total_next;
      idx_reg          <= idx_next;
      best_idx_reg     <= best_idx_next;
      best_cnt_reg     <= best_cnt_next;
      winner_reg       <= winner_next;
      winner_count_reg <= winner_count_next;
      result_valid_reg <= result_valid_next;
`ifdef VOTING_TALLY_TIE_EN
      eq_reg           <= eq_next;
      tie_reg          <= tie_next;
`endif
    end
  end

  assign result_valid = result_valid_reg;
  assign winner       = winner_reg;
  assign winner_count = winner_count_reg;
`ifdef VOTING_TALLY_TIE_EN
  assign tie          = tie_reg;
`endif

endmodule

// File: tb/tb_voting_tally_seq.sv
// Scoreboard bench for voting_tally_seq (CAND_BITS=2, MAX_VOTES=4): stimulus pushes
// expected results, a negedge monitor pops them on each result handshake.
module tb_voting_tally_seq;

  localparam int CB = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ballot_valid = 1'b0;
  logic [CB-1:0] ballot = '0;
  logic          ballot_ready;
  logic          close = 1'b0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [CB-1:0] winner;
  logic [CW-1:0] winner_count;
`ifdef VOTING_TALLY_TIE_EN
  logic          tie;
`endif

  typedef struct {
    int w;
    int c;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  voting_tally_seq #(.CAND_BITS(CB), .MAX_VOTES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ballot_valid (ballot_valid),
    .ballot       (ballot),
    .ballot_ready (ballot_ready),
    .close        (close),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .winner       (winner),
    .winner_count (winner_count)
`ifdef VOTING_TALLY_TIE_EN
    ,
    .tie          (tie)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_ballot(input int b);
    ballot_valid = 1'b1;
    ballot       = CB'(b);
    check("ballot_ready", int'(ballot_ready), 1);
    tick();
    ballot_valid = 1'b0;
  endtask

  task automatic do_close();
    close = 1'b1;
    tick();
    close = 1'b0;
  endtask

  task automatic expect_result(input int w, input int c, input int t);
    exp_t e;
    e.w = w; e.c = c; e.t = t;
    exp_q.push_back(e);
  endtask

  // Called right after the close edge; result_valid must rise exactly 5 edges later.
  task automatic wait_result();
    int n = 0;
    check("rv_low_after_close", int'(result_valid), 0);
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    check("close_latency", n, 5);
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("rv_drop", int'(result_valid), 0);
    check("idle_ready_low", int'(ballot_ready), 0);
  endtask

  // Monitor: compares every accepted result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] result winner=%0d count=%0d (expected %0d/%0d)",
                 winner, winner_count, e.w, e.c);
        check("winner", int'(winner), e.w);
        check("winner_count", int'(winner_count), e.c);
`ifdef VOTING_TALLY_TIE_EN
        check("tie", int'(tie), e.t);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #22;
    rst = 1'b0;
    tick();
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_winner_count", int'(winner_count), 0);
    check("rst_ballot_ready", int'(ballot_ready), 0);
`ifdef VOTING_TALLY_TIE_EN
    check("rst_tie", int'(tie), 0);
`endif

    $display("[TB] election majority 1,1,2,3");
    do_start();
    send_ballot(1); send_ballot(1); send_ballot(2); send_ballot(3);
    expect_result(1, 2, 0);
    do_close();
    wait_result();
    take_result();

    $display("[TB] election tie 3,0,3,0");
    do_start();
    send_ballot(3); send_ballot(0); send_ballot(3); send_ballot(0);
    expect_result(0, 2, 1);
    do_close();
    wait_result();
    take_result();

    $display("[TB] election empty");
    do_start();
    expect_result(0, 0, 1);
    do_close();
    wait_result();
    take_result();

    $display("[TB] election saturation 5x ballot 2");
    do_start();
    ballot_valid = 1'b1;
    ballot       = CB'(2);
    for (int i = 0; i < 5; i++) begin
      check("sat_ready", int'(ballot_ready), (i < 4) ? 1 : 0);
      tick();
    end
    ballot_valid = 1'b0;
    expect_result(2, 4, 0);
    do_close();
    wait_result();
    take_result();

    $display("[TB] election backpressure 0,3,3");
    do_start();
    send_ballot(0); send_ballot(3); send_ballot(3);
    expect_result(3, 2, 0);
    do_close();
    wait_result();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_held", int'(result_valid), 1);
      check("bp_winner_held", int'(winner), 3);
      check("bp_count_held", int'(winner_count), 2);
    end
    take_result();

    $display("[TB] election reset mid-collect");
    do_start();
    send_ballot(3); send_ballot(1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", int'(ballot_ready), 0);
    check("mid_rst_winner", int'(winner), 0);
    check("mid_rst_count", int'(winner_count), 0);
    check("mid_rst_valid", int'(result_valid), 0);
    #3 rst = 1'b0;
    tick();
    do_close();
    for (int i = 0; i < 8; i++) tick();
    check("close_ignored", int'(result_valid), 0);
    do_start();
    send_ballot(3);
    expect_result(3, 1, 0);
    do_close();
    wait_result();
    take_result();

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
